// File: rtl/fb_write_arbiter.sv
// Round-robin owner-per-frame arbiter for the frame-buffer write port.
// Optional grant watchdog: define GRANT_TIMEOUT_EN.
module fb_write_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ADDR_BITS      = 17,
  parameter int DATA_BITS      = 15,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       px_clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           rq_write,
  input  logic [N_REQ-1:0]           writing,
  input  logic [N_REQ-1:0]           enable_mem,
  input  logic [N_REQ*ADDR_BITS-1:0] write_addr,
  input  logic [N_REQ*DATA_BITS-1:0] px_data,
  output logic [N_REQ-1:0]           ack_write,
  output logic                       mem_en,
  output logic [ADDR_BITS-1:0]       mem_addr,
  output logic [DATA_BITS-1:0]       mem_data,
  output logic [IW-1:0]              grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY,
    RELEASE
  } state_t;

  state_t        state;
  logic [IW-1:0] rr;
  logic [IW-1:0] pick;
  logic [IW-1:0] nxt;
  logic          hit;
  logic          have_owner;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    hit  = 1'b0;
    pick = rr;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      logic [IW-1:0] jw;
      j = int'(rr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jw = IW'(j);
      if (!hit && rq_write[jw]) begin
        hit  = 1'b1;
        pick = jw;
      end
    end
  end

  always_comb begin
    int j;
    j = int'(grant_id) + 1;
    if (j >= N_REQ) j = 0;
    nxt = IW'(j);
  end

`ifdef GRANT_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr         <= '0;
      grant_id   <= '0;
      ack_write  <= '0;
      have_owner <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            grant_id   <= pick;
            ack_write  <= N_REQ'(1) << pick;
            have_owner <= 1'b1;
            state      <= GRANT;
`ifdef GRANT_TIMEOUT_EN
            cnt        <= '0;
`endif
          end
        end
        GRANT: begin
          if (writing[grant_id]) begin
            state <= BUSY;
`ifdef GRANT_TIMEOUT_EN
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state       <= RELEASE;
            ack_write   <= '0;
            rr          <= nxt;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        BUSY: begin
          if (!writing[grant_id]) begin
            state     <= RELEASE;
            ack_write <= '0;
            rr        <= nxt;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Cores move their address on negedge, so the mux adds no latency.
  assign busy     = (state != IDLE);
  assign mem_en   = (state == GRANT || state == BUSY) ?
                    enable_mem[grant_id] : 1'b0;
  assign mem_addr = have_owner ?
                    write_addr[grant_id*ADDR_BITS +: ADDR_BITS] : '0;
  assign mem_data = have_owner ?
                    px_data[grant_id*DATA_BITS +: DATA_BITS] : '0;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter, N_REQ=2.
// Timeout checks follow GRANT_TIMEOUT_EN with TIMEOUT_CYCLES=16.
module tb_fb_write_arbiter;
  localparam int N  = 2;
  localparam int AB = 17;
  localparam int DB = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  rq = '0;
  logic [N-1:0]  wr = '0;
  logic [N-1:0]  en = 2'b01;
  logic [AB-1:0] a0 = 17'h100;
  logic [AB-1:0] a1 = 17'h200;
  logic [DB-1:0] d0 = 15'h1234;
  logic [DB-1:0] d1 = 15'h0555;
  logic [N-1:0]  ack;
  logic          mem_en;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_data;
  logic [0:0]    gid;
  logic          busy;
  logic          terr;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .N_REQ(N), .ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT_CYCLES(16)
  ) dut (
    .px_clk(clk),
    .reset(rst_n),
    .rq_write(rq),
    .writing(wr),
    .enable_mem(en),
    .write_addr({a1, a0}),
    .px_data({d1, d0}),
    .ack_write(ack),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .grant_id(gid),
    .busy(busy),
    .timeout_err(terr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag);
    int w;
    int want;
    w = 0;
    while (ack == '0 && w < 20) begin
      tick();
      w++;
    end
    check({tag, "_onehot"}, 32'($onehot(ack)), 1);
    check({tag, "_q"}, 32'(exp_q.size() > 0), 1);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    check({tag, "_ack"}, 32'(ack), 32'(1) << want);
    check({tag, "_id"}, 32'(gid), want);
  endtask

  initial begin
    #2;
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_id", 32'(gid), 0);
    check("rst_terr", 32'(terr), 0);
    check("rst_men", 32'(mem_en), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_data", 32'(mem_data), 0);
    tick(2);
    rst_n = 1'b1;
    tick();

    // single requester
    rq = 2'b01;
    exp_q.push_back(0);
    tick();
    check("t1_lat", 32'(ack), 1);
    expect_grant("t1");
    check("t1_busy", 32'(busy), 1);
    rq = 2'b00;
    check("t1_men", 32'(mem_en), 1);
    check("t1_addr", 32'(mem_addr), 32'h100);
    check("t1_data", 32'(mem_data), 32'h1234);
    wr = 2'b01;
    tick();
    a0 = 17'h101;
    #1;
    check("t1_track", 32'(mem_addr), 32'h101);
    tick(9);
    wr = 2'b00;
    tick();
    check("t1_drop", 32'(ack), 0);
    check("t1_rel_busy", 32'(busy), 1);
    check("t1_rel_men", 32'(mem_en), 0);
    tick();
    check("t1_idle", 32'(busy), 0);
    check("t1_last", 32'(mem_addr), 32'h101);

    // simultaneous requests from reset, with non-owner noise
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    rq = 2'b11;
    exp_q.push_back(0);
    exp_q.push_back(1);
    tick();
    expect_grant("t2a");
    rq = 2'b10;
    wr = 2'b01;
    en = 2'b00;
    tick();
    for (int i = 0; i < 6; i++) begin
      wr[1] = i[0];
      en[1] = ~i[0];
      #1;
      check("t5_noise_en", 32'(mem_en), 0);
      tick();
      check("t5_noise_ack", 32'(ack), 1);
      check("t5_noise_busy", 32'(busy), 1);
    end
    wr = 2'b00;
    en = 2'b00;
    tick();
    check("t2_rel", 32'(ack), 0);
    tick();
    check("t2_idle", 32'(ack), 0);
    tick();
    check("t2_second", 32'(ack), 2);
    expect_grant("t2b");

    // core 0 waits while core 1 owns the port
    rq = 2'b01;
    exp_q.push_back(0);
    wr = 2'b10;
    en = 2'b10;
    tick();
    check("t3_men_own", 32'(mem_en), 1);
    en = 2'b01;
    #1;
    check("t3_men_other", 32'(mem_en), 0);
    tick(3);
    check("t3_wait", 32'(ack), 2);
    wr = 2'b00;
    tick();
    check("t3_rel", 32'(ack), 0);
    expect_grant("t3");
    rq = 2'b00;
    wr = 2'b01;
    tick();
    wr = 2'b00;
    tick(2);

    // reset mid-BUSY restarts with pointer 0
    rq = 2'b10;
    exp_q.push_back(1);
    tick();
    expect_grant("t4");
    rq = 2'b00;
    a1 = 17'h1F3A;
    en = 2'b10;
    wr = 2'b10;
    tick();
    check("t4_addr", 32'(mem_addr), 32'h1F3A);
    check("t4_men", 32'(mem_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_r_ack", 32'(ack), 0);
    check("t4_r_men", 32'(mem_en), 0);
    check("t4_r_busy", 32'(busy), 0);
    check("t4_r_addr", 32'(mem_addr), 0);
    #3;
    rst_n = 1'b1;
    wr = 2'b00;
    en = 2'b00;
    rq = 2'b11;
    exp_q.push_back(0);
    tick();
    expect_grant("t4_rr0");
    rq = 2'b00;

    // grant held with writing low
    tick(15);
    check("t6_hold", 32'(ack), 1);
    tick();
`ifdef GRANT_TIMEOUT_EN
    check("t6_to_ack", 32'(ack), 0);
    check("t6_to_err", 32'(terr), 1);
    rq = 2'b10;
    exp_q.push_back(1);
    expect_grant("t6_next");
    check("t6_sticky", 32'(terr), 1);
    rq = 2'b00;
`else
    check("t6_no_to", 32'(ack), 1);
    check("t6_no_err", 32'(terr), 0);
    wr = 2'b01;
    tick();
    wr = 2'b00;
    tick(2);
    check("t6_done", 32'(busy), 0);
`endif
    check("q_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
endmodule
